// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Turns a stream of received PS/2 set-2 bytes into key events
//                (scancode, extended flag, release flag, ASCII), tracks the
//                shift/ctrl/caps-lock state and queues events in a FWFT FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [7:0] key_scan,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_ascii,
  output logic       key_shift,
  output logic       key_ctrl,
  output logic       caps_lock,
  output logic       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  localparam logic [7:0] C_E0 = 8'hE0;
  localparam logic [7:0] C_F0 = 8'hF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_emit;
  logic   w_ext;
  logic   w_brk;
  logic   w_ignored;

  // Modifier and lock state
  logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps, r_caps_held;
  logic w_shift, w_ctrl;

  // Event FIFO
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_pop, w_push, w_drop, w_full, w_nonempty;
  logic [17:0]   w_entry, w_head;

  logic [5:0]  w_letter;   // {hit, index 0..25}
  logic [16:0] w_digit;    // {hit, unshifted char, shifted char}
  logic [7:0]  w_ascii;

  // Letter lookup: returns {hit, alphabet index}
  function automatic logic [5:0] letter_lookup(input logic [7:0] c);
    case (c)
      8'h1C: return {1'b1, 5'd0};   8'h32: return {1'b1, 5'd1};
      8'h21: return {1'b1, 5'd2};   8'h23: return {1'b1, 5'd3};
      8'h24: return {1'b1, 5'd4};   8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};   8'h33: return {1'b1, 5'd7};
      8'h43: return {1'b1, 5'd8};   8'h3B: return {1'b1, 5'd9};
      8'h42: return {1'b1, 5'd10};  8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};  8'h31: return {1'b1, 5'd13};
      8'h44: return {1'b1, 5'd14};  8'h4D: return {1'b1, 5'd15};
      8'h15: return {1'b1, 5'd16};  8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};  8'h2C: return {1'b1, 5'd19};
      8'h3C: return {1'b1, 5'd20};  8'h2A: return {1'b1, 5'd21};
      8'h1D: return {1'b1, 5'd22};  8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};  8'h1A: return {1'b1, 5'd25};
      default: return 6'd0;
    endcase
  endfunction

  // Digit lookup: returns {hit, unshifted char, shifted char}
  function automatic logic [16:0] digit_lookup(input logic [7:0] c);
    case (c)
      8'h45: return {1'b1, 8'h30, 8'h29};
      8'h16: return {1'b1, 8'h31, 8'h21};
      8'h1E: return {1'b1, 8'h32, 8'h40};
      8'h26: return {1'b1, 8'h33, 8'h23};
      8'h25: return {1'b1, 8'h34, 8'h24};
      8'h2E: return {1'b1, 8'h35, 8'h25};
      8'h36: return {1'b1, 8'h36, 8'h5E};
      8'h3D: return {1'b1, 8'h37, 8'h26};
      8'h3E: return {1'b1, 8'h38, 8'h2A};
      8'h46: return {1'b1, 8'h39, 8'h28};
      default: return 17'd0;
    endcase
  endfunction

  assign w_shift   = r_lshift | r_rshift;
  assign w_ctrl    = r_lctrl | r_rctrl;
  assign w_ignored = (rx_data == 8'hE1) || (rx_data == 8'hAA) || (rx_data == 8'hFA) ||
                     (rx_data == 8'hFE) || (rx_data == 8'hEE) || (rx_data == 8'h00) ||
                     (rx_data == 8'hFF);

  // Prefix state register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Prefix decode: next state and event strobe with its ext/break flags
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    if (rx_done_tick) begin
      case (r_state)
        IDLE: begin
          if (rx_data == C_E0)      w_state_nxt = GOT_E0;
          else if (rx_data == C_F0) w_state_nxt = GOT_F0;
          else if (!w_ignored)      w_emit = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == C_F0) w_state_nxt = GOT_E0F0;
          else begin
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        GOT_F0: begin
          w_state_nxt = IDLE;
          if (rx_data != C_E0 && rx_data != C_F0) begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
          end
        end
        GOT_E0F0: begin
          w_state_nxt = IDLE;
          if (rx_data != C_E0 && rx_data != C_F0) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ASCII translation using the modifier state from before this byte
  always_comb begin
    w_letter = letter_lookup(rx_data);
    w_digit  = digit_lookup(rx_data);
    w_ascii  = 8'h00;
    if (w_brk) begin
      w_ascii = 8'h00;
    end else if (w_ext) begin
      w_ascii = (rx_data == 8'h5A) ? 8'h0D : 8'h00;
    end else if (w_letter[5]) begin
      if (w_ctrl)                w_ascii = {3'b000, w_letter[4:0]} + 8'd1;
      else if (w_shift ^ r_caps) w_ascii = 8'h41 + {3'b000, w_letter[4:0]};
      else                       w_ascii = 8'h61 + {3'b000, w_letter[4:0]};
    end else if (w_digit[16]) begin
      w_ascii = w_shift ? w_digit[7:0] : w_digit[15:8];
    end else begin
      case (rx_data)
        8'h29:   w_ascii = 8'h20;
        8'h5A:   w_ascii = 8'h0D;
        8'h66:   w_ascii = 8'h08;
        8'h76:   w_ascii = 8'h1B;
        default: w_ascii = 8'h00;
      endcase
    end
  end

  // Modifier tracking; caps toggles only on the first make while not held
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (w_emit) begin
      if (!w_ext && rx_data == 8'h12) r_lshift <= !w_brk;
      if (!w_ext && rx_data == 8'h59) r_rshift <= !w_brk;
      if (rx_data == 8'h14) begin
        if (w_ext) r_rctrl <= !w_brk;
        else       r_lctrl <= !w_brk;
      end
      if (!w_ext && rx_data == 8'h58) begin
        if (w_brk) begin
          r_caps_held <= 1'b0;
        end else begin
          if (!r_caps_held) r_caps <= !r_caps;
          r_caps_held <= 1'b1;
        end
      end
    end
  end

  assign w_entry    = {rx_data, w_ext, w_brk, w_ascii};
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == C_FULL);
  assign w_pop      = rd_en && w_nonempty;
  assign w_push     = w_emit && (!w_full || w_pop);
  assign w_drop     = w_emit && w_full && !w_pop;

  // FIFO storage; contents are masked at the outputs while empty
  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign key_valid     = w_nonempty;
  assign key_scan      = w_nonempty ? w_head[17:10] : 8'h00;
  assign key_ext       = w_nonempty & w_head[9];
  assign key_break     = w_nonempty & w_head[8];
  assign key_ascii     = w_nonempty ? w_head[7:0] : 8'h00;
  assign key_shift     = w_shift;
  assign key_ctrl      = w_ctrl;
  assign caps_lock     = r_caps;
  assign fifo_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Self-checking bench for ps2_key_decoder with a behavioural
//                event/modifier model and directed plus random byte streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int D = 8;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       rd_en = 1'b0;
  logic       key_valid, key_ext, key_break, key_shift, key_ctrl, caps_lock, fifo_overflow;
  logic [7:0] key_scan, key_ascii;

  int n_assert = 0;
  int n_fail   = 0;

  ps2_key_decoder #(.FIFO_DEPTH(D)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rd_en(rd_en), .key_valid(key_valid), .key_scan(key_scan), .key_ext(key_ext),
    .key_break(key_break), .key_ascii(key_ascii), .key_shift(key_shift),
    .key_ctrl(key_ctrl), .caps_lock(caps_lock), .fifo_overflow(fifo_overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] scan;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_t;

  // Reference model state: pending prefixes, key flags, event queue
  ev_t q[$];
  bit  m_e0, m_f0, m_lsh, m_rsh, m_lc, m_rc, m_caps, m_held, m_ovf;

  logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] SHD [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  logic [7:0] POOL [16] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h58, 8'h1C, 8'h1A,
                            8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h76, 8'hAA, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input bit ext, input bit brk);
    bit sh = m_lsh | m_rsh;
    if (brk) return 8'h00;
    if (ext) return (b == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++)
      if (LET[i] == b) begin
        if (m_lc | m_rc) return 8'(i + 1);
        return (sh ^ m_caps) ? 8'(65 + i) : 8'(97 + i);
      end
    for (int i = 0; i < 10; i++)
      if (DIG[i] == b) return sh ? SHD[i] : 8'(48 + i);
    case (b)
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      8'h76:   return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    {m_e0, m_f0, m_lsh, m_rsh, m_lc, m_rc, m_caps, m_held, m_ovf} = '0;
  endtask

  // One clock edge of the model: pop, then decode a byte, then push or drop
  task automatic model_clock(input bit tick, input logic [7:0] b, input bit rd);
    ev_t ev;
    bit  emit = 0;
    if (rd && q.size() > 0) void'(q.pop_front());
    if (tick) begin
      if (!m_e0 && !m_f0 && (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
      end else if (m_f0 && (b == 8'hE0 || b == 8'hF0)) begin
        m_e0 = 0; m_f0 = 0;
      end else if (b == 8'hF0) begin
        m_f0 = 1;
      end else if (b == 8'hE0 && !m_e0) begin
        m_e0 = 1;
      end else begin
        ev = '{scan: b, ext: m_e0, brk: m_f0, ascii: ref_ascii(b, m_e0, m_f0)};
        emit = 1;
        if (!ev.ext && b == 8'h12) m_lsh = !ev.brk;
        if (!ev.ext && b == 8'h59) m_rsh = !ev.brk;
        if (b == 8'h14) begin
          if (ev.ext) m_rc = !ev.brk; else m_lc = !ev.brk;
        end
        if (!ev.ext && b == 8'h58) begin
          if (ev.brk) m_held = 0;
          else begin
            if (!m_held) m_caps = !m_caps;
            m_held = 1;
          end
        end
        m_e0 = 0; m_f0 = 0;
      end
    end
    if (emit) begin
      if (q.size() < D) q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    ev_t h = '0;
    if (q.size() > 0) h = q[0];
    chk({tag, ":valid"}, 32'(key_valid), 32'(q.size() > 0));
    chk({tag, ":scan"},  32'(key_scan),  32'(h.scan));
    chk({tag, ":ext"},   32'(key_ext),   32'(h.ext));
    chk({tag, ":brk"},   32'(key_break), 32'(h.brk));
    chk({tag, ":ascii"}, 32'(key_ascii), 32'(h.ascii));
    chk({tag, ":shift"}, 32'(key_shift), 32'(m_lsh | m_rsh));
    chk({tag, ":ctrl"},  32'(key_ctrl),  32'(m_lc | m_rc));
    chk({tag, ":caps"},  32'(caps_lock), 32'(m_caps));
    chk({tag, ":ovf"},   32'(fifo_overflow), 32'(m_ovf));
  endtask

  // Drive one cycle; rx_data carries junk whenever the strobe is low
  task automatic cycle(input bit tick, input logic [7:0] b, input bit rd);
    @(negedge CLOCK_50);
    rx_done_tick = tick;
    rx_data      = tick ? b : 8'($urandom);
    rd_en        = rd;
    @(posedge CLOCK_50);
    model_clock(tick, b, rd);
    #1;
    check_all("cyc");
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic expect_pop(input string tag, input logic [7:0] s, input bit e,
                            input bit bk, input logic [7:0] a);
    chk({tag, ":valid"}, 32'(key_valid), 32'd1);
    chk({tag, ":event"}, {14'd0, key_scan, key_ext, key_break, key_ascii}, {14'd0, s, e, bk, a});
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int         got;
    logic [7:0] last;
    logic [7:0] seq37 [9] = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C};

    // Reset state
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b1);   // pop on empty is ignored

    // Make/break of A
    send(8'h1C); send(8'hF0); send(8'h1C);
    expect_pop("a_make", 8'h1C, 1'b0, 1'b0, 8'h61);
    expect_pop("a_brk",  8'h1C, 1'b0, 1'b1, 8'h00);
    chk("a_empty", 32'(key_valid), 32'd0);

    // Shift, caps toggle with typematic repeat
    foreach (seq37[i]) send(seq37[i]);
    chk("caps_once", 32'(caps_lock), 32'd1);
    expect_pop("s_make",  8'h12, 1'b0, 1'b0, 8'h00);
    expect_pop("shift_A", 8'h1C, 1'b0, 1'b0, 8'h41);
    expect_pop("s_brk",   8'h12, 1'b0, 1'b1, 8'h00);
    expect_pop("c_make1", 8'h58, 1'b0, 1'b0, 8'h00);
    expect_pop("c_make2", 8'h58, 1'b0, 1'b0, 8'h00);
    expect_pop("c_brk",   8'h58, 1'b0, 1'b1, 8'h00);
    expect_pop("caps_A",  8'h1C, 1'b0, 1'b0, 8'h41);

    // Extended codes and ctrl letters
    send(8'hE0); send(8'hF0); send(8'h14); send(8'hE0); send(8'h5A);
    send(8'h14); send(8'h21); send(8'hF0); send(8'h14);
    expect_pop("rctrl_brk", 8'h14, 1'b1, 1'b1, 8'h00);
    expect_pop("kp_enter",  8'h5A, 1'b1, 1'b0, 8'h0D);
    expect_pop("lctrl_mk",  8'h14, 1'b0, 1'b0, 8'h00);
    expect_pop("ctrl_c",    8'h21, 1'b0, 1'b0, 8'h03);
    expect_pop("lctrl_brk", 8'h14, 1'b0, 1'b1, 8'h00);
    chk("ctrl_off", 32'(key_ctrl), 32'd0);

    // Overflow, then a full push with simultaneous pop
    repeat (D + 1) send(8'h29);
    chk("ovf_set", 32'(fifo_overflow), 32'd1);
    cycle(1'b1, 8'h16, 1'b1);
    got  = 0;
    last = 8'h00;
    for (int i = 0; i < 2 * D + 4; i++) begin
      if (!key_valid) break;
      last = key_scan;
      got++;
      cycle(1'b0, 8'h00, 1'b1);
    end
    chk("ovf_kept", 32'(got), 32'(D));
    chk("full_rw_last", 32'(last), 32'h16);
    chk("ovf_sticky", 32'(fifo_overflow), 32'd1);

    // Reset mid-prefix; byte arriving with reset release is decoded from idle
    send(8'h29); send(8'hE0); send(8'hF0);
    @(negedge CLOCK_50);
    rst = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h1C; rd_en = 1'b0;
    #1;
    model_reset();
    check_all("rst_imm");
    @(posedge CLOCK_50);
    #1;
    check_all("rst_hold");
    @(negedge CLOCK_50);
    rst = 1'b0;
    @(posedge CLOCK_50);
    model_clock(1'b1, 8'h1C, 1'b0);
    #1;
    check_all("rst_rel");
    cycle(1'b0, 8'h00, 1'b0);
    expect_pop("after_rst", 8'h1C, 1'b0, 1'b0, 8'h61);

    // Random byte streams against the model
    for (int i = 0; i < 600; i++) begin
      bit         tk = ($urandom_range(0, 3) != 0);
      int         r  = $urandom_range(0, 17);
      logic [7:0] b  = (r < 16) ? POOL[r] : 8'($urandom);
      bit         rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(tk, b, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
